pkt_tx_engine: RTL and testbench
================================

# pkt_tx_engine

Parametrised, register-programmed packet transmitter, successor to the fixed-frame transmit block. Software fills a payload buffer and sets length and mode through a small register port, then issues a start command. The engine streams a framed packet on a valid/ready byte-stream interface: header, length, payload and trailer. It supports backpressure, abort, looped retransmission with a programmable inter-packet gap, and sticky status/error reporting.

## Interface
- DATA_W, 8: stream and register data width; must be ≥ LEN_W
- DEPTH, 16: payload buffer entries; power of two
- HDR0, 8'hDE / HDR1, 8'hAD: header words
- TRL0, 8'hBE / TRL1, 8'hEF: trailer words
- clk  in  1  clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- addr  in  3  register address
- wr  in  1  register write strobe
- wr_data  in  DATA_W  write data
- rd  in  1  register read strobe
- rd_data  out  DATA_W  read data, registered
- tx_en  out  1  beat valid
- tx_data  out  DATA_W  beat data
- tx_sof / tx_eof  out  1  first / last beat of packet
- tx_ready  in  1  sink accepts beat when tx_en && tx_ready

## Operation
- Register map:
  - 0 CMD (W): b0 start, b1 abort, b2 loop, b3 clr_wptr. b0, b1 and b3 are self-clearing; b2 is held. Reads return {loop} in b2, all other bits 0.
  - 1 STATUS: b0 busy (RO), b1 done (sticky), b2 err (sticky); b1/b2 are write-1-to-clear.
  - 2 LEN (RW): payload length, LEN_W = $clog2(DEPTH+1) bits.
  - 3 BUF (W): writes buf[wptr], then wptr++ with wrap at DEPTH.
  - 4 GAP (RW): idle cycles between looped packets.
  - Other addresses: reads return 0, writes are ignored.
- Packet = HDR0, HDR1, LEN (zero-extended), buf[0..LEN-1], TRL0, TRL1. That is LEN+5 beats.
- FSM states: IDLE → HDR0 → HDR1 → LENB → PAY (LEN beats; skipped if LEN=0) → TRL0 → TRL1 → (loop ? GAP : IDLE). GAP counts GAP cycles, then goes to HDR0. If GAP=0, HDR0 follows TRL1 back-to-back.
- A state advances only on an accepted beat (tx_en && tx_ready).
- LEN and GAP are snapshotted at start and again at each loop restart.
- busy = state != IDLE. done sets on accepted TRL1 when leaving to IDLE.
- Error cases; each sets err and has no other effect:
  - start while busy
  - start with LEN > DEPTH (stays IDLE)
  - BUF write while busy
  - LEN/GAP write while busy
- Abort: from any non-IDLE state, go to IDLE next edge. tx_en falls, no tx_eof, done is not set, loop clears.
- Clearing loop (CMD write with b2=0) mid-packet: the current packet completes, then the engine goes to IDLE.
- Abort and start in the same write: abort wins, and start is not accepted.

## Timing
- Reset values: rd_data=0, tx_en=0, tx_data=0, tx_sof=0, tx_eof=0. Also state=IDLE, wptr=0, all registers 0, loop=0.
- Reset asserted mid-packet drops all outputs immediately (asynchronous). The buffer contents are unspecified afterwards.
- All outputs are registered.
- Start written in cycle N → tx_en=1, tx_data=HDR0, tx_sof=1 in cycle N+1.
- While tx_en && !tx_ready: tx_data, tx_sof and tx_eof are held stable.
- After an accepted beat, the next beat is presented in the following cycle (full throughput when tx_ready=1).
- Accepted TRL1 in cycle M:
  - no loop: tx_en=0 in M+1, busy=0 in M+1
  - loop: tx_en=0 for GAP cycles, then HDR0
- rd in cycle N → rd_data valid in N+1. rd_data holds its value when rd=0. STATUS reads reflect state at edge N.
- Register write and read at the same address in the same cycle returns the old value.

## Structure
- Package pkt_tx_pkg holds:
  - register address localparams (REG_CMD..REG_GAP)
  - CMD/STATUS bit indices
  - state enum
  - default header/trailer constants
- Sub-module pkt_tx_buf: DEPTH×DATA_W storage with a synchronous write port and a combinational read port indexed by payload counter. No reset on storage.
- Top level holds the register decode, FSM, counters and output registers.

## Test plan
- Write BUF 05,10,20,30,40,50, LEN=6, CMD=01, tx_ready=1 → 11 consecutive beats DE AD 06 05 10 20 30 40 50 BE EF. sof on beat 1, eof on beat 11. STATUS then reads 02.
- Same packet with tx_ready toggled 1,0,0,1 repeating → identical beat sequence; data stable during stalls; no beat duplicated or lost.
- LEN=0 start → 5 beats DE AD 00 BE EF. LEN=17 (DEPTH=16) start → no tx_en, STATUS=04.
- loop=1, GAP=3, LEN=2 → packets repeat with exactly 3 idle cycles between eof and the next sof. Clear loop mid-payload → that packet completes, then the engine stays IDLE.
- Abort during payload beat 3 → tx_en=0 next cycle, no eof, STATUS=00. Start during busy → err set, stream unaffected.
- Assert rst during PAY → all outputs 0 immediately. After release, STATUS=00 and wptr=0: the next BUF write lands in buf[0].

Source files
------------

// File: rtl/pkt_tx_pkg.sv
// Shared register map, command/status bit positions, FSM states and default
// framing words for the packet transmit engine.
package pkt_tx_pkg;

  localparam logic [2:0] REG_CMD    = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_BUF    = 3'd3;
  localparam logic [2:0] REG_GAP    = 3'd4;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;
  localparam int CMD_LOOP  = 2;
  localparam int CMD_CLRW  = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LENB, S_PAY, S_TRL0, S_TRL1, S_GAP
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'hDE;
  localparam logic [7:0] DEF_HDR1 = 8'hAD;
  localparam logic [7:0] DEF_TRL0 = 8'hBE;
  localparam logic [7:0] DEF_TRL1 = 8'hEF;

endpackage

// File: rtl/pkt_tx_buf.sv
// Payload storage: synchronous write from the register port, combinational
// read addressed by the engine's payload counter. Storage is not reset.
module pkt_tx_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_tx_engine.sv
// Register-programmed packet transmitter: frames buf[0..LEN-1] as
// HDR0 HDR1 LEN payload TRL0 TRL1 on a valid/ready byte stream.
import pkt_tx_pkg::*;

module pkt_tx_engine #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 16,
  parameter logic [DATA_W-1:0] HDR0   = DATA_W'(DEF_HDR0),
  parameter logic [DATA_W-1:0] HDR1   = DATA_W'(DEF_HDR1),
  parameter logic [DATA_W-1:0] TRL0   = DATA_W'(DEF_TRL0),
  parameter logic [DATA_W-1:0] TRL1   = DATA_W'(DEF_TRL1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_sof,
  output logic              tx_eof,
  input  logic              tx_ready
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  state_t            state;
  logic [LEN_W-1:0]  len_reg, len_q, pcnt;
  logic [DATA_W-1:0] gap_reg, gcnt, buf_rdata, rd_val;
  logic [AW-1:0]     wptr;
  logic              loop_reg, done, err;
  logic              busy, accepted, buf_we;
  logic              wr_cmd, wr_stat, wr_len, wr_buf, wr_gap;
  logic              cmd_start, cmd_abort, start_ok, err_set, to_idle;

  assign busy     = (state != S_IDLE);
  assign accepted = tx_en && tx_ready;
  assign wr_cmd   = wr && (addr == REG_CMD);
  assign wr_stat  = wr && (addr == REG_STATUS);
  assign wr_len   = wr && (addr == REG_LEN);
  assign wr_buf   = wr && (addr == REG_BUF);
  assign wr_gap   = wr && (addr == REG_GAP);

  // Abort takes precedence: a start issued alongside it is simply dropped.
  assign cmd_abort = wr_cmd && wr_data[CMD_ABORT];
  assign cmd_start = wr_cmd && wr_data[CMD_START] && !wr_data[CMD_ABORT];
  assign start_ok  = cmd_start && !busy && (len_reg <= MAX_LEN);
  assign err_set   = (cmd_start && (busy || (len_reg > MAX_LEN))) ||
                     ((wr_buf || wr_len || wr_gap) && busy);
  assign to_idle   = (state == S_TRL1) && accepted && !loop_reg && !cmd_abort;
  assign buf_we    = wr_buf && !busy;

  pkt_tx_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (pcnt[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    rd_val = '0;
    case (addr)
      REG_CMD:    rd_val[CMD_LOOP] = loop_reg;
      REG_STATUS: begin
        rd_val[STAT_BUSY] = busy;
        rd_val[STAT_DONE] = done;
        rd_val[STAT_ERR]  = err;
      end
      REG_LEN:    rd_val = DATA_W'(len_reg);
      REG_GAP:    rd_val = gap_reg;
      default:    rd_val = '0;
    endcase
  end

  // Register file, sticky status and read-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg  <= '0;
      gap_reg  <= '0;
      wptr     <= '0;
      loop_reg <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_cmd) loop_reg <= wr_data[CMD_LOOP] && !wr_data[CMD_ABORT];
      if (wr_cmd && wr_data[CMD_CLRW]) wptr <= '0;
      else if (buf_we)                 wptr <= wptr + AW'(1);
      if (wr_len && !busy) len_reg <= wr_data[LEN_W-1:0];
      if (wr_gap && !busy) gap_reg <= wr_data;
      if (wr_stat && wr_data[STAT_DONE]) done <= 1'b0;
      if (wr_stat && wr_data[STAT_ERR])  err  <= 1'b0;
      if (to_idle) done <= 1'b1;
      if (err_set) err  <= 1'b1;
      if (rd) rd_data <= rd_val;
    end
  end

  // Framing FSM; pcnt always indexes the next payload byte to present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      len_q   <= '0;
      pcnt    <= '0;
      gcnt    <= '0;
      tx_en   <= 1'b0;
      tx_data <= '0;
      tx_sof  <= 1'b0;
      tx_eof  <= 1'b0;
    end else if (cmd_abort && busy) begin
      state  <= S_IDLE;
      tx_en  <= 1'b0;
      tx_sof <= 1'b0;
      tx_eof <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_ok) begin
          state   <= S_HDR0;
          len_q   <= len_reg;
          pcnt    <= '0;
          tx_en   <= 1'b1;
          tx_data <= HDR0;
          tx_sof  <= 1'b1;
        end
        S_HDR0: if (accepted) begin
          state   <= S_HDR1;
          tx_data <= HDR1;
          tx_sof  <= 1'b0;
        end
        S_HDR1: if (accepted) begin
          state   <= S_LENB;
          tx_data <= DATA_W'(len_q);
        end
        S_LENB, S_PAY: if (accepted) begin
          if (pcnt == len_q) begin
            state   <= S_TRL0;
            tx_data <= TRL0;
          end else begin
            state   <= S_PAY;
            tx_data <= buf_rdata;
            pcnt    <= pcnt + LEN_W'(1);
          end
        end
        S_TRL0: if (accepted) begin
          state   <= S_TRL1;
          tx_data <= TRL1;
          tx_eof  <= 1'b1;
        end
        S_TRL1: if (accepted) begin
          tx_eof <= 1'b0;
          len_q  <= len_reg;
          pcnt   <= '0;
          if (!loop_reg) begin
            state <= S_IDLE;
            tx_en <= 1'b0;
          end else if (gap_reg == '0) begin
            state   <= S_HDR0;
            tx_data <= HDR0;
            tx_sof  <= 1'b1;
          end else begin
            state <= S_GAP;
            tx_en <= 1'b0;
            gcnt  <= gap_reg - DATA_W'(1);
          end
        end
        S_GAP: begin
          if (!loop_reg) begin
            state <= S_IDLE;
          end else if (gcnt == '0) begin
            state   <= S_HDR0;
            tx_en   <= 1'b1;
            tx_data <= HDR0;
            tx_sof  <= 1'b1;
          end else begin
            gcnt <= gcnt - DATA_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_tx_engine.sv
// Self-checking bench for pkt_tx_engine: register vectors, framed packets
// under several backpressure patterns, loop/gap, abort, errors and reset.
module tb_pkt_tx_engine;
  import pkt_tx_pkg::*;

  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] addr = '0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       tx_en, tx_sof, tx_eof;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;

  always #5 clk = ~clk;

  pkt_tx_engine dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data), .tx_en(tx_en), .tx_data(tx_data), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .tx_ready(tx_ready)
  );

  typedef struct { logic [7:0] d; logic sof; logic eof; int cyc; } beat_t;
  typedef struct { bit is_wr; logic [2:0] a; logic [7:0] d; logic [7:0] exp; } vec_t;

  int    total = 0, bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  bit    stall_chk = 1'b1;
  beat_t beats[$];
  beat_t exp_q[$];
  vec_t  vt[$];
  logic [7:0] m_buf [16];
  int    m_wptr = 0;
  logic  p_en = 0, p_rdy = 0, p_sof = 0, p_eof = 0;
  logic [7:0] p_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Beat capture and hold-under-stall check
  always @(negedge clk) begin
    if (tx_en && tx_ready)
      beats.push_back('{d: tx_data, sof: tx_sof, eof: tx_eof, cyc: cyc});
    if (stall_chk && p_en && !p_rdy)
      check("stall_hold", 32'({tx_en, tx_sof, tx_eof, tx_data}),
            32'({1'b1, p_sof, p_eof, p_data}));
    p_en   <= tx_en;
    p_rdy  <= tx_ready;
    p_sof  <= tx_sof;
    p_eof  <= tx_eof;
    p_data <= tx_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(logic [2:0] a, logic [7:0] d);
    @(posedge clk); #2;
    addr = a; wr = 1'b1; wr_data = d;
    @(posedge clk); #2;
    wr = 1'b0;
  endtask

  task automatic reg_read(logic [2:0] a, output logic [7:0] v);
    @(posedge clk); #2;
    addr = a; rd = 1'b1;
    @(posedge clk); #2;
    rd = 1'b0;
    v = rd_data;
  endtask

  task automatic buf_write(logic [7:0] d);
    reg_write(REG_BUF, d);
    m_buf[m_wptr] = d;
    m_wptr = (m_wptr + 1) % 16;
  endtask

  task automatic clr_wptr();
    reg_write(REG_CMD, 8'h08);
    m_wptr = 0;
  endtask

  // Expected frame: HDR0 HDR1 LEN buf[0..LEN-1] TRL0 TRL1
  function automatic void add_pkt(int len);
    logic [7:0] seq[$];
    seq = '{8'hDE, 8'hAD, 8'(len)};
    for (int i = 0; i < len; i++) seq.push_back(m_buf[i]);
    seq.push_back(8'hBE);
    seq.push_back(8'hEF);
    for (int i = 0; i < seq.size(); i++)
      exp_q.push_back('{d: seq[i], sof: (i == 0), eof: (i == seq.size() - 1), cyc: 0});
  endfunction

  task automatic wait_beats(int n, int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_pkt(string tag);
    check({tag, "_count"}, 32'(beats.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i),
            32'({beats[i].sof, beats[i].eof, beats[i].d}),
            32'({exp_q[i].sof, exp_q[i].eof, exp_q[i].d}));
  endtask

  task automatic status_expect(string tag, logic [7:0] exp);
    logic [7:0] v;
    reg_read(REG_STATUS, v);
    check(tag, 32'(v), 32'(exp));
    reg_write(REG_STATUS, 8'h06);
  endtask

  task automatic send_and_check(string tag, int len, int mode);
    ready_mode = mode;
    exp_q.delete();
    add_pkt(len);
    beats.delete();
    reg_write(REG_CMD, 8'h01);
    wait_beats(len + 5, 600);
    repeat (3) @(negedge clk);
    check_pkt(tag);
    ready_mode = 0;
  endtask

  initial begin
    logic [7:0] v;
    int len;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_tx_en",   32'(tx_en),   32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_sof",  32'(tx_sof),  32'd0);
    check("rst_tx_eof",  32'(tx_eof),  32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    vt.push_back('{0, REG_STATUS, 8'h00, 8'h00});
    vt.push_back('{0, REG_CMD,    8'h00, 8'h00});
    vt.push_back('{0, REG_LEN,    8'h00, 8'h00});
    vt.push_back('{0, REG_GAP,    8'h00, 8'h00});
    vt.push_back('{1, REG_LEN,    8'h06, 8'h00});
    vt.push_back('{0, REG_LEN,    8'h00, 8'h06});
    vt.push_back('{1, REG_GAP,    8'h03, 8'h00});
    vt.push_back('{0, REG_GAP,    8'h00, 8'h03});
    vt.push_back('{1, REG_GAP,    8'h00, 8'h00});
    vt.push_back('{0, REG_GAP,    8'h00, 8'h00});
    vt.push_back('{1, REG_CMD,    8'h04, 8'h00});
    vt.push_back('{0, REG_CMD,    8'h00, 8'h04});
    vt.push_back('{1, REG_CMD,    8'h00, 8'h00});
    vt.push_back('{0, REG_CMD,    8'h00, 8'h00});
    vt.push_back('{0, 3'd5,       8'h00, 8'h00});
    vt.push_back('{1, 3'd6,       8'hFF, 8'h00});
    vt.push_back('{0, 3'd6,       8'h00, 8'h00});
    vt.push_back('{0, REG_STATUS, 8'h00, 8'h00});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].is_wr) reg_write(vt[i].a, vt[i].d);
      else begin
        reg_read(vt[i].a, v);
        check($sformatf("vec%0d_addr%0d", i, vt[i].a), 32'(v), 32'(vt[i].exp));
      end
    end

    // Same-cycle write and read of LEN returns the old value
    @(posedge clk); #2;
    addr = REG_LEN; wr = 1'b1; wr_data = 8'h09; rd = 1'b1;
    @(posedge clk); #2;
    wr = 1'b0; rd = 1'b0;
    check("rw_same_cycle_old", 32'(rd_data), 32'h06);
    reg_read(REG_LEN, v);
    check("rw_same_cycle_new", 32'(v), 32'h09);
    reg_write(REG_LEN, 8'h06);

    clr_wptr();
    foreach (vt[i]) ;
    buf_write(8'h05); buf_write(8'h10); buf_write(8'h20);
    buf_write(8'h30); buf_write(8'h40); buf_write(8'h50);

    send_and_check("basic", 6, 0);
    if (beats.size() == 11)
      check("basic_back_to_back", 32'(beats[10].cyc - beats[0].cyc), 32'd10);
    check("basic_idle_after", 32'(tx_en), 32'd0);
    status_expect("basic_status", 8'h02);

    send_and_check("stall", 6, 1);
    status_expect("stall_status", 8'h02);

    reg_write(REG_LEN, 8'h00);
    send_and_check("len0", 0, 0);
    status_expect("len0_status", 8'h02);

    reg_write(REG_LEN, 8'd17);
    beats.delete();
    reg_write(REG_CMD, 8'h01);
    repeat (10) @(negedge clk);
    check("len17_no_beats", 32'(beats.size()), 32'd0);
    status_expect("len17_status", 8'h04);

    // Looping with a 3-cycle gap, loop cleared during the third payload
    clr_wptr();
    buf_write(8'hAA); buf_write(8'hBB);
    reg_write(REG_LEN, 8'h02);
    reg_write(REG_GAP, 8'h03);
    exp_q.delete();
    add_pkt(2); add_pkt(2); add_pkt(2);
    beats.delete();
    reg_write(REG_CMD, 8'h05);
    wait_beats(17, 300);
    reg_write(REG_CMD, 8'h00);
    wait_beats(21, 300);
    repeat (20) @(negedge clk);
    check_pkt("loop");
    if (beats.size() >= 15) begin
      check("loop_gap1", 32'(beats[7].cyc - beats[6].cyc), 32'd4);
      check("loop_gap2", 32'(beats[14].cyc - beats[13].cyc), 32'd4);
    end
    status_expect("loop_status", 8'h02);
    reg_write(REG_GAP, 8'h00);

    // Abort while the third payload byte is on the bus
    clr_wptr();
    buf_write(8'h05); buf_write(8'h10); buf_write(8'h20);
    buf_write(8'h30); buf_write(8'h40); buf_write(8'h50);
    reg_write(REG_LEN, 8'h06);
    exp_q.delete();
    add_pkt(6);
    beats.delete();
    reg_write(REG_CMD, 8'h01);
    repeat (4) @(posedge clk);
    reg_write(REG_CMD, 8'h02);
    check("abort_tx_en", 32'(tx_en), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_count", 32'(beats.size()), 32'd6);
    for (int i = 0; i < 6 && i < beats.size(); i++)
      check($sformatf("abort_beat%0d", i),
            32'({beats[i].sof, beats[i].eof, beats[i].d}),
            32'({exp_q[i].sof, exp_q[i].eof, exp_q[i].d}));
    reg_read(REG_STATUS, v);
    check("abort_status", 32'(v), 32'h00);
    reg_read(REG_CMD, v);
    check("abort_loop", 32'(v), 32'h00);

    // Start and LEN write while busy flag err but leave the stream alone
    exp_q.delete();
    add_pkt(6);
    beats.delete();
    reg_write(REG_CMD, 8'h01);
    repeat (2) @(posedge clk);
    reg_write(REG_CMD, 8'h01);
    reg_write(REG_LEN, 8'h03);
    wait_beats(11, 100);
    repeat (3) @(negedge clk);
    check_pkt("busy_start");
    reg_read(REG_LEN, v);
    check("busy_len_kept", 32'(v), 32'h06);
    status_expect("busy_status", 8'h06);

    // Asynchronous reset in the middle of the payload
    stall_chk = 1'b0;
    reg_read(REG_LEN, v);
    reg_write(REG_CMD, 8'h01);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_en",   32'(tx_en),   32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_tx_sof",  32'(tx_sof),  32'd0);
    check("midrst_tx_eof",  32'(tx_eof),  32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    stall_chk = 1'b1;
    m_wptr = 0;
    reg_read(REG_STATUS, v);
    check("midrst_status", 32'(v), 32'h00);
    buf_write(8'h77);
    reg_write(REG_LEN, 8'h01);
    send_and_check("post_rst", 1, 0);
    status_expect("post_rst_status", 8'h02);

    // Randomised payloads under random backpressure
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(0, 16);
      clr_wptr();
      for (int i = 0; i < len; i++) buf_write(8'($urandom));
      reg_write(REG_LEN, 8'(len));
      send_and_check($sformatf("rand%0d", k), len, 2);
      status_expect($sformatf("rand%0d_status", k), 8'h02);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
